// File: rtl/mult_pkg.sv
// Shared encodings and widths for the 8x8 sequential multiplier slice.
package mult_pkg;

    localparam int OPERAND_W = 8;
    localparam int PRODUCT_W = 16;

    // Multiplier controller state_out encodings
    typedef enum logic [2:0] {
        CTRL_IDLE      = 3'b000,
        CTRL_LSB       = 3'b001,
        CTRL_MID       = 3'b010,
        CTRL_MSB       = 3'b011,
        CTRL_CALC_DONE = 3'b100,
        CTRL_ERR       = 3'b101
    } ctrl_state_e;

    // Operand sequencer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_START = 2'b01,
        S_RUN   = 2'b10,
        S_RESP  = 2'b11
    } seq_state_e;

endpackage

// File: rtl/mult_watchdog.sv
// Clearable cycle counter; expired is high once the count reaches TIMEOUT.
// The count saturates there so a stalled enable cannot wrap it back to 0.
module mult_watchdog
    import mult_pkg::*;
#(
    parameter int TIMEOUT = 15,
    localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic clk,
    input  logic reset_a,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [W-1:0] TC = W'(TIMEOUT);

    logic [W-1:0] count;

    // Count enabled cycles, clear has priority, hold at terminal count
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && count != TC)
            count <= count + 1'b1;
    end

    assign expired = (count == TC);

endmodule

// File: rtl/mult_op_sequencer.sv
// Front-end for the sequential multiplier: takes operand requests, pulses
// start, tracks nibble steps, retries on controller ERR or timeout, and
// returns the product (or an error) over a valid/ready response channel.
module mult_op_sequencer
    import mult_pkg::*;
#(
    parameter int MAX_RETRY = 1,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 reset_a,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [OPERAND_W-1:0] req_a,
    input  logic [OPERAND_W-1:0] req_b,
    output logic [OPERAND_W-1:0] op_a,
    output logic [OPERAND_W-1:0] op_b,
    output logic                 mul_start,
    output logic [1:0]           mul_count,
    input  logic                 mul_clk_en,
    input  logic                 mul_done,
    input  logic [2:0]           mul_state,
    input  logic [PRODUCT_W-1:0] mul_product,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [PRODUCT_W-1:0] rsp_product,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    seq_state_e    state;
    logic [RW-1:0] retry_cnt;
    logic          wd_expired;
    logic          wd_clr;
    logic          wd_en;

    // Watchdog restarts with every start pulse and only runs while waiting on the controller
    assign wd_clr = (state == S_START);
    assign wd_en  = (state == S_RUN);

    mult_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset_a (reset_a),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    // Gated by reset so the request side looks closed while the controller is held in reset
    assign req_ready = (state == S_IDLE) && !reset_a;
    assign busy      = (state != S_IDLE);

    // Sequencer FSM with registered datapath/controller/response outputs
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state       <= S_IDLE;
            op_a        <= '0;
            op_b        <= '0;
            mul_start   <= 1'b0;
            mul_count   <= '0;
            retry_cnt   <= '0;
            rsp_valid   <= 1'b0;
            rsp_product <= '0;
            rsp_err     <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_a      <= req_a;
                        op_b      <= req_b;
                        retry_cnt <= '0;
                        mul_start <= 1'b1;
                        mul_count <= '0;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    mul_count <= '0;
                    state     <= S_RUN;
                end
                S_RUN: begin
                    if (mul_clk_en)
                        mul_count <= mul_count + 2'd1;
                    // done outranks a coincident ERR
                    if (mul_done) begin
                        rsp_product <= mul_product;
                        rsp_err     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= S_RESP;
                    end else if (mul_state == CTRL_ERR || wd_expired) begin
                        if (retry_cnt < RETRY_LIMIT) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            mul_start <= 1'b1;
                            mul_count <= '0;
                            state     <= S_START;
                        end else begin
                            rsp_product <= '0;
                            rsp_err     <= 1'b1;
                            rsp_valid   <= 1'b1;
                            state       <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_op_sequencer.sv
// Directed bench: a cycle-scripted controller model plus a table of operand
// vectors with hand-computed products, latencies and retry pulse cycles.
module tb_mult_op_sequencer;
    import mult_pkg::*;

    logic        clk = 1'b0;
    logic        reset_a;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_a, req_b;
    logic [7:0]  op_a, op_b;
    logic        mul_start;
    logic [1:0]  mul_count;
    logic        mul_clk_en;
    logic        mul_done;
    logic [2:0]  mul_state;
    logic [15:0] mul_product;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_product;
    logic        rsp_err;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    // controller model knobs
    int err_runs = 0;
    bit hang     = 1'b0;
    int run_idx  = 0;
    int ph       = -1;
    bit cur_err  = 1'b0;

    mult_op_sequencer #(.MAX_RETRY(1), .TIMEOUT(15)) dut (
        .clk         (clk),
        .reset_a     (reset_a),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .op_a        (op_a),
        .op_b        (op_b),
        .mul_start   (mul_start),
        .mul_count   (mul_count),
        .mul_clk_en  (mul_clk_en),
        .mul_done    (mul_done),
        .mul_state   (mul_state),
        .mul_product (mul_product),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_err     (rsp_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Controller model: values set at the negedge of cycle k are what the DUT samples ending cycle k.
    // Start seen in cycle c -> LSB c+1, MID c+2, MID c+3, MSB c+4, CALC_DONE c+5.
    always @(negedge clk) begin
        if (reset_a) begin
            ph = -1; mul_state = CTRL_IDLE; mul_done = 1'b0; mul_clk_en = 1'b0;
        end else if (mul_start) begin
            ph = 0; cur_err = (run_idx < err_runs); run_idx = run_idx + 1;
            mul_done = 1'b0; mul_clk_en = 1'b0;
        end else if (ph >= 0) begin
            ph = ph + 1; mul_done = 1'b0; mul_clk_en = 1'b0;
            if (cur_err && ph == 2) begin
                mul_state = CTRL_ERR; ph = -1;
            end else if (hang && ph >= 4) begin
                mul_state = CTRL_MSB; mul_clk_en = (ph == 4);
            end else begin
                case (ph)
                    1: begin mul_state = CTRL_LSB; mul_clk_en = 1'b1; end
                    2: begin mul_state = CTRL_MID; mul_clk_en = 1'b1; end
                    3: begin mul_state = CTRL_MID; mul_clk_en = 1'b1; end
                    4: begin mul_state = CTRL_MSB; mul_clk_en = 1'b1; end
                    5: begin
                        mul_state = CTRL_CALC_DONE; mul_done = 1'b1;
                        mul_product = {8'h00, op_a} * {8'h00, op_b};
                    end
                    default: begin mul_state = CTRL_IDLE; ph = -1; end
                endcase
            end
        end
    end

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int          err_runs;
        bit          hang;
        logic [15:0] prod;
        bit          err;
        int          lat;     // cycle rsp_valid first appears (handshake = cycle 0)
        int          start2;  // cycle of the retry start pulse, 0 = none
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Issue one request (caller sits at a negedge) and trace it up to the response cycle
    task automatic run_row(input vec_t v);
        int c;
        int cnt_base;
        err_runs = v.err_runs; hang = v.hang; run_idx = 0;
        cnt_base = v.err ? 0 : ((v.start2 == 0) ? 2 : v.start2 + 1);
        chk("req_ready_idle", 32'(req_ready), 32'(1));
        req_valid = 1'b1; req_a = v.a; req_b = v.b;
        step(); c = 1; req_valid = 1'b0;
        while (c <= v.lat) begin
            chk("mul_start", 32'(mul_start), 32'(c == 1 || c == v.start2));
            if (cnt_base != 0 && c >= cnt_base && c < cnt_base + 4)
                chk("mul_count", 32'(mul_count), 32'(c - cnt_base));
            chk("rsp_valid_timing", 32'(rsp_valid), 32'(c == v.lat));
            chk("busy", 32'(busy), 32'(1));
            if (c == v.lat) break;
            step(); c++;
        end
        for (int k = 0; k < 60 && !rsp_valid; k++) step();
        chk("rsp_arrived", 32'(rsp_valid), 32'(1));
        chk("rsp_product", 32'(rsp_product), 32'(v.prod));
        chk("rsp_err", 32'(rsp_err), 32'(v.err));
        chk("op_a_stable", 32'(op_a), 32'(v.a));
        chk("op_b_stable", 32'(op_b), 32'(v.b));
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(rsp_valid), 32'(0));
        chk("req_ready_back", 32'(req_ready), 32'(1));
        chk("busy_idle", 32'(busy), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "tb timeout");
    end

    initial begin
        vec_t bp;
        tbl[0] = '{8'h0F, 8'h11, 0, 1'b0, 16'h00FF, 1'b0,  7,  0};
        tbl[1] = '{8'hFF, 8'hFF, 0, 1'b0, 16'hFE01, 1'b0,  7,  0};
        tbl[2] = '{8'h00, 8'h55, 0, 1'b0, 16'h0000, 1'b0,  7,  0};
        tbl[3] = '{8'h12, 8'h34, 0, 1'b0, 16'h03A8, 1'b0,  7,  0};
        tbl[4] = '{8'h0F, 8'h11, 1, 1'b0, 16'h00FF, 1'b0, 10,  4}; // one ERR, retry succeeds
        tbl[5] = '{8'hC3, 8'h02, 2, 1'b0, 16'h0000, 1'b1,  7,  4}; // ERR twice -> error
        tbl[6] = '{8'h80, 8'h02, 0, 1'b1, 16'h0000, 1'b1, 35, 18}; // watchdog twice -> error
        tbl[7] = '{8'h80, 8'h02, 0, 1'b0, 16'h0100, 1'b0,  7,  0};

        reset_a = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        mul_clk_en = 1'b0; mul_done = 1'b0; mul_state = CTRL_IDLE; mul_product = '0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_mul_start", 32'(mul_start), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_op", 32'({op_a, op_b}), 32'(0));
        chk("rst_rsp", 32'({rsp_product, rsp_err, mul_count}), 32'(0));
        step(); step();
        reset_a = 1'b0;
        #1;
        chk("req_ready_after_rst", 32'(req_ready), 32'(1));

        // table: back-to-back rows, each starting the cycle after the previous handshake
        for (int i = 0; i < 8; i++) begin
            run_row(tbl[i]);
            finish_rsp();
        end

        // backpressure: hold response 5 cycles while a new request is offered
        bp = '{8'h21, 8'h03, 0, 1'b0, 16'h0063, 1'b0, 7, 0};
        run_row(bp);
        req_valid = 1'b1; req_a = 8'hAA; req_b = 8'h55;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_rsp_valid", 32'(rsp_valid), 32'(1));
            chk("bp_rsp_product", 32'(rsp_product), 32'(16'h0063));
            chk("bp_rsp_err", 32'(rsp_err), 32'(0));
            chk("bp_req_ready", 32'(req_ready), 32'(0));
            chk("bp_op_a", 32'(op_a), 32'(8'h21));
        end
        req_valid = 1'b0;
        finish_rsp();
        chk("bp_no_capture", 32'({op_a, op_b}), 32'(16'h2103));

        // reset in cycle 4 of an operation: everything clears, no response
        err_runs = 0; hang = 1'b0; run_idx = 0;
        req_valid = 1'b1; req_a = 8'h0F; req_b = 8'h11;
        step(); req_valid = 1'b0;
        step(); step(); step();
        reset_a = 1'b1;
        #1;
        chk("mid_rst_outputs", 32'({mul_start, rsp_valid, busy, req_ready, rsp_err}), 32'(0));
        chk("mid_rst_regs", 32'({op_a, op_b, mul_count}), 32'(0));
        chk("mid_rst_product", 32'(rsp_product), 32'(0));
        step(); step();
        reset_a = 1'b0;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'(1));
        for (int k = 0; k < 8; k++) begin
            step();
            chk("post_rst_no_rsp", 32'({rsp_valid, busy}), 32'(0));
        end
        run_row(tbl[0]);
        finish_rsp();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
